// File: rtl/ssd_pkg.sv
// Shared types, segment constants and digit helpers for the seven-segment display path.
package ssd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConvRe,
    StConvIm,
    StCommit
  } state_e;

  // Digit code: 0..9 are BCD, plus two non-numeric codes.
  typedef logic [3:0] digit_t;

  localparam digit_t DIG_BLANK = 4'hA;
  localparam digit_t DIG_MINUS = 4'hB;

  // Segment patterns {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Display contents "   0   0", digit 7 in the top nibble.
  localparam logic [31:0] DISP_RESET = 32'hAAA0_AAA0;

  function automatic logic [6:0] seg_decode(input digit_t d);
    logic [6:0] s;
    case (d)
      4'd0:      s = SEG_0;
      4'd1:      s = SEG_1;
      4'd2:      s = SEG_2;
      4'd3:      s = SEG_3;
      4'd4:      s = SEG_4;
      4'd5:      s = SEG_5;
      4'd6:      s = SEG_6;
      4'd7:      s = SEG_7;
      4'd8:      s = SEG_8;
      4'd9:      s = SEG_9;
      DIG_MINUS: s = SEG_MINUS;
      default:   s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Leading-zero blanking of a three-digit magnitude; ones are always shown.
  function automatic logic [11:0] fmt3(input logic [3:0] h, input logic [3:0] t,
                                       input logic [3:0] o);
    digit_t dh;
    digit_t dt;
    dh = (h == 4'd0) ? DIG_BLANK : h;
    dt = (h == 4'd0 && t == 4'd0) ? DIG_BLANK : t;
    return {dh, dt, o};
  endfunction

endpackage

// File: rtl/ssd_cplx_display_ctrl_if.sv
// Result handshake and display pins of the complex-adder display controller.
interface ssd_cplx_display_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] re;
  logic [7:0] im;
  logic       busy;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output in_valid, re, im,
    input  in_ready, busy, an, seg, dp
  );

  modport slave (
    input  in_valid, re, im,
    output in_ready, busy, an, seg, dp
  );
endinterface

// File: rtl/ssd_bcd_iter.sv
// Iterative double-dabble: one load cycle, then eight add-3/shift cycles.
module ssd_bcd_iter (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [19:0] sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [19:0] adj;

  // Next state: load on start, otherwise adjust BCD nibbles and shift while running.
  always_comb begin
    adj = sh_q;
    for (int n = 0; n < 3; n++) begin
      if (adj[8+4*n +: 4] >= 4'd5) begin
        adj[8+4*n +: 4] = adj[8+4*n +: 4] + 4'd3;
      end
    end
    sh_d  = sh_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      sh_d  = {12'b0, bin};
      cnt_d = 3'd0;
      run_d = 1'b1;
    end else if (run_q) begin
      sh_d  = {adj[18:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        run_d = 1'b0;
      end
    end
  end

  // Engine state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // High during the cycle whose closing edge performs the final shift.
  assign done     = run_q && (cnt_q == 3'd7);
  assign hundreds = sh_q[19:16];
  assign tens     = sh_q[15:12];
  assign ones     = sh_q[11:8];

endmodule

// File: rtl/ssd_cplx_display_ctrl.sv
// Converts a signed re/im pair to BCD on one shared engine and scans it onto 8 digits.
module ssd_cplx_display_ctrl
  import ssd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input logic                    clk,
  input logic                    rst,
  ssd_cplx_display_ctrl_if.slave bus_if
);

  localparam logic [15:0] TickMax = 16'(SCAN_DIV - 1);

  state_e          state_q;
  logic            in_ready_q;
  logic            start_q;
  logic            sign_re_q, sign_im_q;
  logic [7:0]      mag_re_q, mag_im_q;
  logic [11:0]     re_dig_q;
  digit_t [7:0]    disp_q;

  logic [15:0]     tick_q;
  logic [2:0]      idx_q;
  logic [7:0]      an_q;
  logic [6:0]      seg_q;

  logic            eng_done;
  logic [3:0]      eng_h, eng_t, eng_o;
  logic [7:0]      eng_bin;

  // The engine is loaded on the first cycle of each conversion state.
  assign eng_bin = (state_q == StConvIm) ? mag_im_q : mag_re_q;

  ssd_bcd_iter u_bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (start_q),
    .bin      (eng_bin),
    .done     (eng_done),
    .hundreds (eng_h),
    .tens     (eng_t),
    .ones     (eng_o)
  );

  // Sequencing FSM with registered handshake, engine start and display commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      in_ready_q <= 1'b1;
      start_q    <= 1'b0;
      sign_re_q  <= 1'b0;
      sign_im_q  <= 1'b0;
      mag_re_q   <= '0;
      mag_im_q   <= '0;
      re_dig_q   <= '0;
      disp_q     <= DISP_RESET;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus_if.in_valid) begin
            sign_re_q  <= bus_if.re[7];
            sign_im_q  <= bus_if.im[7];
            mag_re_q   <= bus_if.re[7] ? (~bus_if.re + 8'd1) : bus_if.re;
            mag_im_q   <= bus_if.im[7] ? (~bus_if.im + 8'd1) : bus_if.im;
            in_ready_q <= 1'b0;
            start_q    <= 1'b1;
            state_q    <= StConvRe;
          end
        end
        StConvRe: begin
          if (eng_done) begin
            start_q <= 1'b1;
            state_q <= StConvIm;
          end
        end
        StConvIm: begin
          // Engine still holds the real result on the edge that reloads it.
          if (start_q) begin
            re_dig_q <= {eng_h, eng_t, eng_o};
          end
          if (eng_done) begin
            state_q <= StCommit;
          end
        end
        StCommit: begin
          disp_q     <= {sign_re_q ? DIG_MINUS : DIG_BLANK,
                         fmt3(re_dig_q[11:8], re_dig_q[7:4], re_dig_q[3:0]),
                         sign_im_q ? DIG_MINUS : DIG_BLANK,
                         fmt3(eng_h, eng_t, eng_o)};
          in_ready_q <= 1'b1;
          state_q    <= StIdle;
        end
        default: begin
          in_ready_q <= 1'b1;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  // Free-running digit scan with registered anode and segment drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
      idx_q  <= '0;
      an_q   <= 8'b1111_1110;
      seg_q  <= SEG_0;
    end else begin
      if (tick_q == TickMax) begin
        tick_q <= '0;
        idx_q  <= idx_q + 3'd1;
      end else begin
        tick_q <= tick_q + 16'd1;
      end
      an_q  <= ~(8'b1 << idx_q);
      seg_q <= seg_decode(disp_q[idx_q]);
    end
  end

  assign bus_if.in_ready = in_ready_q;
  assign bus_if.busy     = ~in_ready_q;
  assign bus_if.an       = an_q;
  assign bus_if.seg      = seg_q;
  assign bus_if.dp       = 1'b1;

endmodule

// File: tb/tb_ssd_cplx_display_ctrl.sv
// Directed scoreboard bench for the display controller, scanned with a short slot time.
module tb_ssd_cplx_display_ctrl;

  localparam int unsigned SCAN_DIV = 4;

  typedef logic [7:0][6:0] disp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  disp_t sb_q[$];

  always #5 clk = ~clk;

  ssd_cplx_display_ctrl_if dut_if ();

  ssd_cplx_display_ctrl #(
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (dut_if)
  );

  // Watchdog against a stuck run.
  initial begin
    #900000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Four segment codes for one signed value: sign, hundreds, tens, ones.
  function automatic logic [27:0] half(input logic [7:0] v);
    int m, hu, te, on;
    logic [6:0] s3, s2, s1, s0;
    m  = v[7] ? (256 - int'(v)) : int'(v);
    hu = m / 100;
    te = (m / 10) % 10;
    on = m % 10;
    s3 = v[7] ? 7'b0111111 : 7'h7F;
    s2 = (hu == 0) ? 7'h7F : seg_of(hu);
    s1 = (hu == 0 && te == 0) ? 7'h7F : seg_of(te);
    s0 = seg_of(on);
    return {s3, s2, s1, s0};
  endfunction

  function automatic disp_t model(input logic [7:0] r, input logic [7:0] i);
    return {half(r), half(i)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (dut_if.in_ready !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk(tag, 64'(dut_if.in_ready), 64'(1));
  endtask

  // Offers a pair for exactly one accept edge, then scrambles the data lines.
  task automatic accept(input logic [7:0] r, input logic [7:0] i);
    wait_ready("ready_before_accept");
    dut_if.in_valid = 1'b1;
    dut_if.re       = r;
    dut_if.im       = i;
    step();
    dut_if.in_valid = 1'b0;
    dut_if.re       = 8'($urandom);
    dut_if.im       = 8'($urandom);
    chk("busy_after_accept", 64'(dut_if.busy), 64'(1));
  endtask

  // Counts edges after the accept edge until in_ready returns.
  task automatic wait_done(input string tag);
    int n = 0;
    while (dut_if.in_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, 64'(n), 64'(19));
  endtask

  // Collects one full scan by decoding which anode is low.
  task automatic read_disp(output disp_t d);
    logic [7:0] seen;
    logic [7:0] oh;
    d    = '1;
    seen = '0;
    step();
    step();
    for (int c = 0; c < 40; c++) begin
      for (int k = 0; k < 8; k++) begin
        oh = 8'b1 << k;
        if (dut_if.an == ~oh) begin
          d[k]    = dut_if.seg;
          seen[k] = 1'b1;
        end
      end
      step();
    end
    chk("scan_cover", 64'(seen), 64'(8'hFF));
  endtask

  task automatic check_disp(input string tag);
    disp_t got;
    disp_t exp;
    read_disp(got);
    exp = sb_q.pop_front();
    chk(tag, 64'(got), 64'(exp));
  endtask

  initial begin
    logic [7:0] oh;
    logic [7:0] lr, li;
    int acc, last, slot;
    dut_if.in_valid = 1'b0;
    dut_if.re       = '0;
    dut_if.im       = '0;

    // Reset state and free scan pattern.
    repeat (3) step();
    chk("reset_outputs", 64'({dut_if.in_ready, dut_if.busy, dut_if.dp, dut_if.an, dut_if.seg}),
        64'({1'b1, 1'b0, 1'b1, 8'hFE, 7'h40}));
    rst = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      step();
      slot = (n - 1) / 4;
      oh   = 8'b1 << slot;
      chk("scan_reset", 64'({dut_if.an, dut_if.seg}),
          64'({~oh, (slot % 4 == 0) ? 7'h40 : 7'h7F}));
    end

    // Basic conversions.
    sb_q.push_back(model(8'd37, 8'hFB));
    accept(8'd37, 8'hFB);
    wait_done("latency_37_m5");
    check_disp("disp_37_m5");

    sb_q.push_back(model(8'h80, 8'd127));
    accept(8'h80, 8'd127);
    wait_done("latency_m128_127");
    check_disp("disp_m128_127");

    // in_valid held high with new data every cycle.
    acc  = 0;
    last = 0;
    lr   = '0;
    li   = '0;
    dut_if.in_valid = 1'b1;
    for (int c = 0; c < 70; c++) begin
      dut_if.re = 8'(c * 13 + 1);
      dut_if.im = 8'(200 - c * 7);
      if (dut_if.in_ready === 1'b1) begin
        if (acc > 0) chk("accept_spacing", 64'(c - last), 64'(20));
        acc++;
        last = c;
        lr   = dut_if.re;
        li   = dut_if.im;
      end
      step();
    end
    dut_if.in_valid = 1'b0;
    chk("accept_count", 64'(acc), 64'(4));
    wait_ready("ready_after_stream");
    sb_q.push_back(model(lr, li));
    check_disp("disp_stream_last");

    // Reset in the middle of the imaginary conversion.
    accept(8'd99, 8'h9C);
    repeat (11) step();
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", 64'({dut_if.in_ready, dut_if.busy, dut_if.dp, dut_if.an, dut_if.seg}),
        64'({1'b1, 1'b0, 1'b1, 8'hFE, 7'h40}));
    step();
    step();
    rst = 1'b0;
    sb_q.push_back(model(8'd0, 8'd0));
    check_disp("disp_after_rst");

    sb_q.push_back(model(8'hFF, 8'd100));
    accept(8'hFF, 8'd100);
    wait_done("latency_after_rst");
    check_disp("disp_m1_100");

    // Every real value with a zero imaginary part.
    for (int v = 0; v < 256; v++) begin
      sb_q.push_back(model(8'(v), 8'd0));
      accept(8'(v), 8'd0);
      wait_ready("sweep_ready");
      check_disp("sweep_disp");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssd_cplx_display_ctrl.md
# ssd_cplx_display_ctrl

Sequencing controller that owns the seven-segment display path of the complex adder. It accepts one signed 8-bit real/imaginary result pair through a valid/ready handshake. It converts both magnitudes to BCD one at a time on a single shared iterative double-dabble engine, then commits the digits to display registers. It continuously time-multiplexes the result onto an 8-digit common-anode display.

## Interface
- SCAN_DIV, 16'd50000: clk cycles per digit refresh slot; legal range 2..65535.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  re/im pair offered.
- in_ready  out  1  high only in IDLE; transfer when in_valid & in_ready at a rising edge.
- re  in  8  real part, two's complement.
- im  in  8  imaginary part, two's complement.
- busy  out  1  equals !in_ready.
- an  out  8  digit enables, active-low, one-hot-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low, held 1.

## Operation
- Accept: latch sign_re/sign_im and magnitudes |re|, |im| as 8-bit unsigned. |-128| = 128.
- FSM states: IDLE, CONV_RE, CONV_IM, COMMIT.
  - IDLE → CONV_RE on accept.
  - CONV_RE → CONV_IM on engine done.
  - CONV_IM → COMMIT on engine done.
  - COMMIT → IDLE unconditionally.
- Engine (sub-module) runs one load cycle, then 8 shift cycles on a 20-bit register {12'b0, bin}.
  - Each shift cycle: every BCD nibble ≥5 gets +3 first, then the whole register shifts left 1.
  - done pulses for 1 cycle with the last shift.
- COMMIT writes the 8 display digit codes in one edge. No partial update is ever visible.
- Digit map (index 7 = leftmost):
  - 7: '-' if sign_re else blank.
  - 6..4: hundreds/tens/ones of |re|.
  - 3: '-' if sign_im else blank.
  - 2..0: hundreds/tens/ones of |im|.
- Leading-zero blanking:
  - hundreds blank if 0.
  - tens blank if hundreds and tens both 0.
  - ones always shown.
- Scan: tick counter counts 0..SCAN_DIV-1 and wraps. On wrap, digit index advances 0→1→…→7→0.
- an/seg are registered from the digit index and digit code.

## Timing
- Reset values:
  - state IDLE, in_ready 1, busy 0, dp 1.
  - tick counter 0, digit index 0.
  - an 8'b1111_1110, seg 7'b1000000 ('0').
  - display registers show "   0   0".
- Latency: accept at edge E0. CONV_RE covers E1–E9, CONV_IM covers E10–E18, COMMIT at E19. New digits are visible in display registers after E19, and in_ready is high after E19.
- Minimum accept-to-accept spacing is 20 cycles.
- in_valid while busy is ignored. re/im are don't-care outside the accept edge.
- an/seg change 1 cycle after the digit index changes.
- Scan runs independently of the FSM. A commit mid-slot takes effect on the next registered an/seg update.
- rst mid-conversion aborts the conversion. All state returns to reset values, and display registers revert to "   0   0".

## Structure
- Package ssd_pkg holds:
  - FSM state enum.
  - Segment constants: SEG_BLANK 7'h7F, SEG_MINUS 7'b0111111, digit 0–9 patterns.
  - Digit-code type: 4-bit BCD plus blank and minus codes.
  - BCD-to-segment decode function.
- One sub-module, ssd_bcd_iter.
  - Ports: clk, rst, start, bin[7:0], done, hundreds, tens, ones.
  - Multi-cycle double-dabble engine shared by both conversions.

## Test plan
- Reset only, SCAN_DIV=4:
  - an cycles FE,FD,FB,…,7F with 4 cycles per slot.
  - Slots 0 and 4 show seg 7'b1000000; all other slots show 7'h7F.
- Accept re=37, im=-5:
  - in_ready low E1–E19.
  - Digits after E19: blank, blank, '3', '7', '-', blank, blank, '5'.
- Accept re=-128, im=127:
  - Digits '-','1','2','8',blank,'1','2','7'.
- Hold in_valid high continuously with alternating data:
  - Exactly one accept per 20 cycles.
  - Pairs offered while busy are never displayed.
- Assert rst at E12 of a conversion:
  - Outputs at reset values immediately; display shows "   0   0".
  - A fresh accept after reset converts correctly.
- Engine sweep with all 256 re values (im=0):
  - Displayed hundreds/tens/ones match |re| for every value, including 0, 5, 9, 10, 99, 100, 127, -128.
